div_arbiter: RTL and testbench

//  Shares one pipelined signed divider (o = a/b, 3-cycle latency, clamped Q4.16 output, no stall) among N_REQ

---
 rtl/div_arbiter_if.sv | 40 ++++
 rtl/div_arbiter.sv | 120 ++++++++++++
 tb/tb_div_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester handshake, divider side-channel and tagged response bus of div_arbiter.
// With `DIV_ARB_DZ_FLAG_EN defined the bus also carries the zero-divisor flag rsp_dz.
interface div_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int A_W   = 9,
    parameter int B_W   = 9,
    parameter int O_W   = 20
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [A_W-1:0]       div_a;
    logic [B_W-1:0]       div_b;
    logic [O_W-1:0]       div_o;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [O_W-1:0]       rsp_o;
`ifdef DIV_ARB_DZ_FLAG_EN
    logic                 rsp_dz;
`endif

    // slave is the arbiter's view; master is the requesters plus divider around it
    modport slave (
        input  req_valid, req_a, req_b, div_o,
        output req_ready, div_a, div_b, rsp_valid, rsp_id, rsp_o
`ifdef DIV_ARB_DZ_FLAG_EN
        , output rsp_dz
`endif
    );

    modport master (
        output req_valid, req_a, req_b, div_o,
        input  req_ready, div_a, div_b, rsp_valid, rsp_id, rsp_o
`ifdef DIV_ARB_DZ_FLAG_EN
        , input rsp_dz
`endif
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one pipelined signed divider among N_REQ requesters, results tagged by ID.
// Optional `DIV_ARB_DZ_FLAG_EN carries a zero-divisor flag alongside each op and reports it as rsp_dz.
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 9,
    parameter int B_W     = 9,
    parameter int O_W     = 20,
    parameter int DIV_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush_req,
    div_arbiter_if.slave  bus,
    output logic          busy,
    output logic          flush_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_id;
    logic [N_REQ-1:0] gnt_vec;
    logic             gnt_any;
    logic             can_grant;
    logic [DIV_LAT:0] tag_vld;
    logic [ID_W-1:0]  tag_id [DIV_LAT+1];
`ifdef DIV_ARB_DZ_FLAG_EN
    logic [DIV_LAT:0] tag_dz;
    logic             gnt_dz;
`endif

    // flush or disable seen this cycle suppresses the grant as well as leaving RUN
    assign can_grant = (state == RUN) && en && !flush_req;

    always_comb begin
        gnt_vec = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && can_grant && bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_id] = 1'b1;
        end
    end

    assign bus.req_ready = gnt_vec;
    assign busy          = |tag_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (flush_req || !en) state_nxt = DRAIN;
            DRAIN: begin
                if (!busy) begin
                    state_nxt  = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // the tag pipe never stalls: its last stage lines up with the divider result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.div_a <= '0;
            bus.div_b <= '0;
            rr_ptr    <= '0;
            tag_vld   <= '0;
            for (int k = 0; k <= DIV_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[DIV_LAT-1:0], gnt_any};
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= DIV_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
            if (gnt_any) begin
                bus.div_a <= bus.req_a[int'(gnt_id)*A_W +: A_W];
                bus.div_b <= bus.req_b[int'(gnt_id)*B_W +: B_W];
                rr_ptr    <= ID_W'((int'(gnt_id) + 1) % N_REQ);
            end
        end
    end

    assign bus.rsp_valid = tag_vld[DIV_LAT];
    assign bus.rsp_id    = tag_id[DIV_LAT];
    assign bus.rsp_o     = bus.div_o;

`ifdef DIV_ARB_DZ_FLAG_EN
    assign gnt_dz = (bus.req_b[int'(gnt_id)*B_W +: B_W] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_dz <= '0;
        end else begin
            tag_dz <= {tag_dz[DIV_LAT-1:0], gnt_any & gnt_dz};
        end
    end

    assign bus.rsp_dz = tag_dz[DIV_LAT];
`endif
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scenarios plus random traffic against a timestamp-based model of div_arbiter.
// Includes a behavioural Q4.16 clamping divider with the same three-edge latency as the real one.
module tb_div_arbiter;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int A_W   = 9;
    localparam int B_W   = 9;
    localparam int O_W   = 20;
    localparam int LAT   = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic flush_req = 1'b0;
    logic busy;
    logic flush_done;

    div_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .O_W(O_W)) bus ();

    div_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .O_W(O_W), .DIV_LAT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush_req (flush_req),
        .bus       (bus.slave),
        .busy      (busy),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    // signed a/b scaled to Q4.16, truncated toward zero and clamped; zero divisor saturates by sign of a
    function automatic logic [O_W-1:0] divRef(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        longint na, nb, q;
        na = longint'($signed(a));
        nb = longint'($signed(b));
        if (nb == 0) q = (na < 0) ? -524288 : 524287;
        else begin
            q = (na * 65536) / nb;
            if (q > 524287) q = 524287;
            if (q < -524288) q = -524288;
        end
        return q[O_W-1:0];
    endfunction

    logic [O_W-1:0] p1, p2;
    always @(posedge clk) begin
        p1 <= divRef(bus.div_a, bus.div_b);
        p2 <= p1;
        bus.div_o <= p2;
    end

    typedef struct {
        int             acc;
        int             id;
        logic [O_W-1:0] o;
        bit             dz;
    } op_t;

    op_t            pend[$];
    int             cyc = 0;
    int             rr = 0;
    int             mode = M_IDLE;
    logic [A_W-1:0] lastA = '0;
    logic [B_W-1:0] lastB = '0;
    bit             v [N_REQ];
    logic [A_W-1:0] ra [N_REQ];
    logic [B_W-1:0] rb [N_REQ];
    int             lastGrant;
    logic           lastRspValid;
    logic [O_W-1:0] lastRspO;
    int             doneCount, doneCyc;
    int             nTests = 0;
    int             nFail = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit enI, input bit flushI);
        en = enI;
        flush_req = flushI;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i] = v[i];
            bus.req_a[i*A_W +: A_W] = ra[i];
            bus.req_b[i*B_W +: B_W] = rb[i];
        end
    endtask

    // one clock: check outputs mid-cycle against the model, then advance the model with this cycle's inputs
    task automatic stepCycle();
        int             expId;
        bit             expRsp;
        logic [N_REQ-1:0] expReady;
        op_t            op;
        @(negedge clk);
        while (pend.size() > 0 && pend[0].acc + LAT < cyc) void'(pend.pop_front());
        expRsp = (pend.size() > 0) && (pend[0].acc + LAT == cyc);
        expId = -1;
        if (mode == M_RUN && en && !flush_req) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (expId < 0 && v[(rr + k) % N_REQ]) expId = (rr + k) % N_REQ;
            end
        end
        expReady = '0;
        if (expId >= 0) expReady[expId] = 1'b1;
        checkOutput("req_ready", bus.req_ready, expReady);
        checkOutput("rsp_valid", bus.rsp_valid, expRsp);
        checkOutput("busy", busy, pend.size() > 0);
        checkOutput("flush_done", flush_done, (mode == M_DRAIN) && (pend.size() == 0));
        checkOutput("div_a", bus.div_a, lastA);
        checkOutput("div_b", bus.div_b, lastB);
        if (expRsp) begin
            checkOutput("rsp_id", bus.rsp_id, pend[0].id);
            checkOutput("rsp_o", bus.rsp_o, pend[0].o);
`ifdef DIV_ARB_DZ_FLAG_EN
            checkOutput("rsp_dz", bus.rsp_dz, pend[0].dz);
`endif
        end
        lastGrant = -1;
        for (int k = 0; k < N_REQ; k++) if (bus.req_ready[k] === 1'b1) lastGrant = k;
        lastRspValid = bus.rsp_valid;
        lastRspO = bus.rsp_o;
        if (flush_done === 1'b1) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (expId >= 0) begin
            op.acc = cyc;
            op.id = expId;
            op.o = divRef(ra[expId], rb[expId]);
            op.dz = (rb[expId] == '0);
            pend.push_back(op);
            rr = (expId + 1) % N_REQ;
            lastA = ra[expId];
            lastB = rb[expId];
            v[expId] = 1'b0;
        end
        case (mode)
            M_IDLE:  if (en) mode = M_RUN;
            M_RUN:   if (flush_req || !en) mode = M_DRAIN;
            default: if (pend.size() == 0) mode = M_IDLE;
        endcase
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic cycles(input int n, input bit enI, input bit flushI);
        for (int i = 0; i < n; i++) begin
            applyStimulus(enI, flushI);
            stepCycle();
        end
    endtask

    task automatic modelReset();
        pend.delete();
        mode = M_IDLE;
        rr = 0;
        lastA = '0;
        lastB = '0;
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
    endtask

    initial begin
        int grants [5];
        int acc3;
        int anyReady;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 1'b0;
            ra[i] = '0;
            rb[i] = 9'd1;
        end
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset div_a", bus.div_a, 0);
        checkOutput("reset div_b", bus.div_b, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset rsp_id", bus.rsp_id, 0);
        checkOutput("reset flush_done", flush_done, 0);
        checkOutput("reset req_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        modelReset();

        // single op from requester 2
        cycles(1, 1'b1, 1'b0);
        v[2] = 1'b1; ra[2] = 9'd10; rb[2] = 9'd5;
        cycles(1, 1'b1, 1'b0);
        checkOutput("t1 grant", lastGrant, 2);
        cycles(4, 1'b1, 1'b0);
        checkOutput("t1 rsp_valid", lastRspValid, 1);
        checkOutput("t1 rsp_o", lastRspO, 20'h20000);

        // two accepts then an asynchronous reset while they are in flight
        v[0] = 1'b1; ra[0] = 9'd20; rb[0] = 9'd3;
        v[1] = 1'b1; ra[1] = 9'h1F0; rb[1] = 9'd7;
        cycles(3, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t4 div_a", bus.div_a, 0);
        checkOutput("t4 busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t4 rsp_valid", bus.rsp_valid, 0);
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
        modelReset();

        // round robin from pointer 0 with every requester asserting continuously
        for (int i = 0; i < N_REQ; i++) begin
            ra[i] = A_W'(17 * (i + 1));
            rb[i] = B_W'(i + 2);
        end
        cycles(1, 1'b1, 1'b0);
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < N_REQ; i++) v[i] = 1'b1;
            cycles(1, 1'b1, 1'b0);
            grants[g] = lastGrant;
        end
        checkOutput("t2 grant0", grants[0], 0);
        checkOutput("t2 grant1", grants[1], 1);
        checkOutput("t2 grant2", grants[2], 2);
        checkOutput("t2 grant3", grants[3], 3);
        checkOutput("t2 grant4", grants[4], 0);
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
        cycles(6, 1'b1, 1'b0);

        // three consecutive accepts followed by a flush
        for (int i = 0; i < 3; i++) v[i] = 1'b1;
        cycles(3, 1'b1, 1'b0);
        acc3 = cyc - 1;
        v[3] = 1'b1;
        doneCount = 0;
        cycles(1, 1'b1, 1'b1);
        checkOutput("t3 no grant on flush", lastGrant, -1);
        v[3] = 1'b0;
        cycles(8, 1'b1, 1'b0);
        checkOutput("t3 flush_done count", doneCount, 1);
        checkOutput("t3 flush_done timing", doneCyc - acc3, LAT + 1);

        // zero divisor passes the divider's saturated value through
        v[1] = 1'b1; ra[1] = 9'd7; rb[1] = 9'd0;
        cycles(5, 1'b1, 1'b0);
        checkOutput("t5 rsp_o", lastRspO, 20'h7FFFF);

        // disabled arbiter never grants
        cycles(8, 1'b0, 1'b0);
        anyReady = 0;
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycles(1, 1'b0, 1'b0);
            if (lastGrant >= 0) anyReady++;
        end
        checkOutput("t6 ready count", anyReady, 0);
        checkOutput("t6 busy", busy, 0);

        // random traffic with occasional flushes, disables and zero divisors
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!v[i] && ($urandom % 2 == 1)) begin
                    v[i] = 1'b1;
                    ra[i] = A_W'($urandom);
                    rb[i] = ($urandom % 8 == 0) ? '0 : B_W'($urandom);
                end
            end
            cycles(1, ($urandom % 16) != 0, ($urandom % 32) == 0);
        end
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
        cycles(10, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
